// File: rtl/i2s_rx_if.sv
// Parallel-side signal bundle of the I2S receiver.
// The master modport drives the serial inputs and observes the decoded samples.
`timescale 1ns/1ps
interface i2s_rx_if #(
  parameter int WIDTH = 16
) ();
  logic             ws_i;
  logic             sdata_i;
  logic [WIDTH-1:0] leftChan_o;
  logic [WIDTH-1:0] rightChan_o;
  logic             valid_o;
  logic             len_err_o;
  logic             locked_o;

  modport master (
    output ws_i, sdata_i,
    input  leftChan_o, rightChan_o, valid_o, len_err_o, locked_o
  );

  modport slave (
    input  ws_i, sdata_i,
    output leftChan_o, rightChan_o, valid_o, len_err_o, locked_o
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S serial receiver: deserialises ws/sdata into left/right sample words
// and strobes valid once per complete stereo frame.
`timescale 1ns/1ps
module i2s_rx #(
  parameter int   WIDTH    = 16,
  parameter logic WS_LEFT  = 1'b1,
  parameter int   MAX_BITS = 64
) (
  input  logic  sclk_i,
  input  logic  rst_i,
  i2s_rx_if.slave bus
);
  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_BITS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ws_q, ws_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] left_hold_q, left_hold_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             valid_q, valid_d;
  logic             len_err_q, len_err_d;
  logic             locked_q, locked_d;

  logic             edge_s;
  logic [CW-1:0]    cnt_inc_s;
  logic [WIDTH-1:0] word_s;

  // Next-state, word assembly and commit logic.
  always_comb begin
    edge_s    = (bus.ws_i != ws_q);
    cnt_inc_s = (cnt_q == MAX_C) ? cnt_q : cnt_q + ONE_C;
    // Bits beyond WIDTH match no position and are dropped.
    for (int i = 0; i < WIDTH; i++) begin
      word_s[i] = (cnt_q == CW'(WIDTH - 1 - i)) ? bus.sdata_i : shift_q[i];
    end

    state_d     = state_q;
    ws_d        = bus.ws_i;
    shift_d     = word_s;
    cnt_d       = cnt_inc_s;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    len_err_d   = 1'b0;

    case (state_q)
      SYNC: begin
        shift_d = '0;
        cnt_d   = '0;
        if (edge_s && (bus.ws_i == WS_LEFT)) begin
          state_d = LEFT;
        end else begin
          state_d = SYNC;
        end
      end
      LEFT: begin
        if (edge_s) begin
          state_d     = RIGHT;
          left_hold_d = word_s;
          shift_d     = '0;
          cnt_d       = '0;
          len_err_d   = (cnt_inc_s != WIDTH_C);
        end else if (cnt_inc_s == MAX_C) begin
          state_d = SYNC;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = LEFT;
        end
      end
      RIGHT: begin
        if (edge_s) begin
          state_d   = LEFT;
          left_d    = left_hold_q;
          right_d   = word_s;
          valid_d   = 1'b1;
          shift_d   = '0;
          cnt_d     = '0;
          len_err_d = (cnt_inc_s != WIDTH_C);
        end else if (cnt_inc_s == MAX_C) begin
          state_d = SYNC;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = RIGHT;
        end
      end
      default: begin
        state_d = SYNC;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase

    locked_d = (state_d != SYNC);
  end

  // State and output registers; ws history resets to the left level.
  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SYNC;
      ws_q        <= WS_LEFT;
      shift_q     <= '0;
      cnt_q       <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      len_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      len_err_q   <= len_err_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.leftChan_o  = left_q;
  assign bus.rightChan_o = right_q;
  assign bus.valid_o     = valid_q;
  assign bus.len_err_o   = len_err_q;
  assign bus.locked_o    = locked_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: the driver queues expected frames and error
// strobes with their cycle stamps; a monitor pops them as the DUT strobes.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam int W = 16;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           stamp;
  } frame_t;

  frame_t frame_q[$];
  int     err_q[$];

  i2s_rx_if #(.WIDTH(W)) bus ();

  i2s_rx #(.WIDTH(W), .WS_LEFT(1'b1), .MAX_BITS(64)) dut (
    .sclk_i (sclk),
    .rst_i  (rst),
    .bus    (bus)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of its queue, including cycle.
  always @(negedge sclk) begin
    if (!rst) begin
      if (bus.valid_o === 1'b1) begin
        if (frame_q.size() == 0) begin
          chk("unexpected_valid", 32'(bus.valid_o), 32'd0);
        end else begin
          frame_t f;
          f = frame_q.pop_front();
          chk("left_sample", 32'(bus.leftChan_o), 32'(f.l));
          chk("right_sample", 32'(bus.rightChan_o), 32'(f.r));
          chk("valid_cycle", 32'(cyc), 32'(f.stamp));
        end
      end
      if (bus.len_err_o === 1'b1) begin
        if (err_q.size() == 0) begin
          chk("unexpected_len_err", 32'(bus.len_err_o), 32'd0);
        end else begin
          int s;
          s = err_q.pop_front();
          chk("len_err_cycle", 32'(cyc), 32'(s));
        end
      end
    end
  end

  task automatic send_bit(input logic ws, input logic d, output int stamp);
    @(negedge sclk);
    bus.ws_i    = ws;
    bus.sdata_i = d;
    stamp       = cyc + 1;
  endtask

  task automatic send_word(input logic ch, input logic [31:0] data, input int n,
                           input logic nxt, output int stamp);
    for (int k = 0; k < n; k++) begin
      send_bit((k == n - 1) ? nxt : ch, data[n-1-k], stamp);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input int ln, input logic [31:0] r, input int rn,
                            input logic [W-1:0] exp_l, input logic [W-1:0] exp_r,
                            input logic err_l, input logic err_r);
    int s1, s2;
    frame_t f;
    send_word(1'b1, l, ln, 1'b0, s1);
    if (err_l) err_q.push_back(s1);
    send_word(1'b0, r, rn, 1'b1, s2);
    if (err_r) err_q.push_back(s2);
    f.l = exp_l;
    f.r = exp_r;
    f.stamp = s2;
    frame_q.push_back(f);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_left"},    32'(bus.leftChan_o),  32'd0);
    chk({tag, "_right"},   32'(bus.rightChan_o), 32'd0);
    chk({tag, "_valid"},   32'(bus.valid_o),     32'd0);
    chk({tag, "_len_err"}, 32'(bus.len_err_o),   32'd0);
    chk({tag, "_locked"},  32'(bus.locked_o),    32'd0);
  endtask

  initial begin
    int s;
    bus.ws_i    = 1'b1;
    bus.sdata_i = 1'b0;
    #3;
    chk_reset_state("reset");

    // Release reset while the line is in the middle of a right word.
    @(negedge sclk);
    bus.ws_i = 1'b0;
    @(negedge sclk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) send_bit(1'b0, k[0], s);
    @(posedge sclk); #1;
    chk("startup_unlocked", 32'(bus.locked_o), 32'd0);
    send_bit(1'b1, 1'b1, s);
    @(posedge sclk); #1;
    chk("startup_locked", 32'(bus.locked_o), 32'd1);

    send_frame(32'hA5C3, 16, 32'h3C5A, 16, 16'hA5C3, 16'h3C5A, 1'b0, 1'b0);
    send_frame(32'h1234, 16, 32'hFEDC, 16, 16'h1234, 16'hFEDC, 1'b0, 1'b0);
    send_frame(32'h0ABC, 12, 32'h0F0F, 16, 16'hABC0, 16'h0F0F, 1'b1, 1'b0);
    send_frame(32'h5555, 16, 32'h10003, 17, 16'h5555, 16'h8001, 1'b0, 1'b1);

    // ws held at the left level for 64 bits: sync lost on the 64th.
    for (int k = 0; k < 63; k++) send_bit(1'b1, k[0], s);
    @(posedge sclk); #1;
    chk("locked_at_63", 32'(bus.locked_o), 32'd1);
    send_bit(1'b1, 1'b0, s);
    @(posedge sclk); #1;
    chk("unlocked_at_64", 32'(bus.locked_o), 32'd0);
    chk("held_left_after_loss", 32'(bus.leftChan_o), 32'h5555);
    for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b1, s);
    @(posedge sclk); #1;
    chk("still_unlocked", 32'(bus.locked_o), 32'd0);
    send_bit(1'b1, 1'b0, s);
    @(posedge sclk); #1;
    chk("relocked", 32'(bus.locked_o), 32'd1);
    send_frame(32'hC3A5, 16, 32'h5AC3, 16, 16'hC3A5, 16'h5AC3, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a left word.
    for (int k = 0; k < 8; k++) send_bit(1'b1, 1'b1, s);
    @(posedge sclk); #2;
    rst = 1'b1;
    #1;
    chk_reset_state("midword_reset");
    repeat (3) @(negedge sclk);
    rst = 1'b0;
    repeat (5) @(negedge sclk);

    chk("frames_pending", 32'(frame_q.size()), 32'd0);
    chk("errs_pending", 32'(err_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
